video_decimator: RTL and testbench

Parametrised single-clock pixel-stream decimator. It drops pixels horizontally by 2^hshift and lines vertically by 2^vshift, with a selectable phase in each direction, and re-packs the kept pixels into full-width output beats. It sits between the frame-buffer read FIFO and the output-side async FIFO in the scaler path. Unlike the fixed /2 and /4 packer, it:
- uses valid/ready handshakes on both sides,
- uses in-band sof/eol framing instead of programmed line lengths,
- supports phase-selectable decimation from 1 to 8 in each direction,
- flushes partial beats with a keep mask.

---
 rtl/video_decimator.sv | 126 ++++++++++++
 tb/tb_video_decimator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_decimator.sv
// video_decimator: drops pixels by 2^hshift and lines by 2^vshift, re-packing kept pixels into full beats.
module video_decimator #(
    parameter int C_LANES  = 8,
    parameter int C_PIX_W  = 16,
    parameter int C_LINE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_en,
    input  logic [1:0]                 cfg_hshift,
    input  logic [1:0]                 cfg_vshift,
    input  logic [2:0]                 cfg_hphase,
    input  logic [2:0]                 cfg_vphase,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [C_LANES*C_PIX_W-1:0] s_data,
    input  logic                       s_sof,
    input  logic                       s_eol,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [C_LANES*C_PIX_W-1:0] m_data,
    output logic [C_LANES-1:0]         m_keep,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       err_sof,
    output logic [C_LINE_W-1:0]        stat_lines_out
);
    localparam int LW = $clog2(C_LANES);

    logic                       in_frame, line_open, sof_pend;
    logic [1:0]                 h_sh, v_sh;
    logic [2:0]                 hph, vph, g;
    logic [C_LINE_W-1:0]        line_cnt;
    logic [C_PIX_W-1:0]         acc [C_LANES];

    logic [1:0]                 h_eff, v_eff;
    logic [2:0]                 hmask, vmask, hph_eff, vph_eff, g_cur;
    logic [C_LINE_W-1:0]        l_cur;
    logic                       frame_cur, kept, completes, s_fire;
    logic [C_PIX_W-1:0]         lane [C_LANES];
    logic [C_PIX_W-1:0]         acc_nx [C_LANES];
    logic [C_LANES*C_PIX_W-1:0] nx_flat;
    logic [C_LANES-1:0]         nkeep;
    logic [LW-1:0]              src;
    int                         n;

    // An accepted sof applies its own config and restarts line/group state on the same beat.
    always_comb begin
        h_eff     = s_sof ? (cfg_en ? cfg_hshift : 2'd0) : h_sh;
        v_eff     = s_sof ? (cfg_en ? cfg_vshift : 2'd0) : v_sh;
        hmask     = (3'd1 << h_eff) - 3'd1;
        vmask     = (3'd1 << v_eff) - 3'd1;
        hph_eff   = s_sof ? cfg_hphase & hmask : hph;
        vph_eff   = s_sof ? cfg_vphase & vmask : vph;
        g_cur     = s_sof ? 3'd0 : g;
        l_cur     = s_sof ? '0 : line_cnt;
        frame_cur = s_sof | in_frame;
        kept      = frame_cur & ((l_cur[2:0] & vmask) == vph_eff);
        completes = kept & (s_eol | (g_cur == hmask));
        s_ready   = ~rst & (~kept | ~m_valid | m_ready | ~completes);
        s_fire    = s_valid & s_ready;
        n         = C_LANES >> h_eff;
        src       = '0;
        nx_flat   = '0;
        for (int j = 0; j < C_LANES; j++)
            lane[j] = s_data[j*C_PIX_W +: C_PIX_W];
        // Slot j belongs to group j / n and takes lane (j mod n)*H + phase.
        for (int j = 0; j < C_LANES; j++) begin
            src       = LW'(((j & (n - 1)) << h_eff) | int'(hph_eff));
            nkeep[j]  = (j >> (LW - int'(h_eff))) <= int'(g_cur);
            acc_nx[j] = ((j >> (LW - int'(h_eff))) == int'(g_cur)) ? lane[src] : (s_sof ? '0 : acc[j]);
            nx_flat[j*C_PIX_W +: C_PIX_W] = acc_nx[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame       <= 1'b0;
            line_open      <= 1'b0;
            sof_pend       <= 1'b0;
            h_sh           <= '0;
            v_sh           <= '0;
            hph            <= '0;
            vph            <= '0;
            g              <= '0;
            line_cnt       <= '0;
            acc            <= '{default: '0};
            m_valid        <= 1'b0;
            m_data         <= '0;
            m_keep         <= '0;
            m_sof          <= 1'b0;
            m_eol          <= 1'b0;
            err_sof        <= 1'b0;
            stat_lines_out <= '0;
        end else begin
            err_sof <= s_fire & s_sof & ((g != 3'd0) | line_open);
            if (m_valid & m_ready & m_eol & (stat_lines_out != '1))
                stat_lines_out <= stat_lines_out + C_LINE_W'(1);
            if (s_fire) begin
                in_frame  <= frame_cur;
                line_open <= frame_cur & ~s_eol;
                sof_pend  <= (s_sof | sof_pend) & ~completes;
                line_cnt  <= l_cur + C_LINE_W'(frame_cur & s_eol);
                g         <= (kept & ~completes) ? g_cur + 3'd1 : 3'd0;
                for (int j = 0; j < C_LANES; j++)
                    acc[j] <= (kept & ~completes) ? acc_nx[j] : '0;
                if (s_sof) begin
                    h_sh           <= h_eff;
                    v_sh           <= v_eff;
                    hph            <= hph_eff;
                    vph            <= vph_eff;
                    stat_lines_out <= '0;
                end
            end
            if (s_fire & completes) begin
                m_valid <= 1'b1;
                m_data  <= nx_flat;
                m_keep  <= nkeep;
                m_sof   <= s_sof | sof_pend;
                m_eol   <= s_eol;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_video_decimator.sv
// tb_video_decimator: scoreboard bench comparing video_decimator against a frame-level pixel model.
module tb_video_decimator;
    localparam int C_LANES  = 8;
    localparam int C_PIX_W  = 16;
    localparam int C_LINE_W = 16;
    localparam int DW       = C_LANES*C_PIX_W;

    typedef struct packed {
        logic [DW-1:0]      d;
        logic [C_LANES-1:0] k;
        logic               s;
        logic               e;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_en;
    logic [1:0]          cfg_hshift, cfg_vshift;
    logic [2:0]          cfg_hphase, cfg_vphase;
    logic                s_valid, s_ready, s_sof, s_eol;
    logic [DW-1:0]       s_data;
    logic                m_valid, m_ready, m_sof, m_eol, err_sof;
    logic [DW-1:0]       m_data;
    logic [C_LANES-1:0]  m_keep;
    logic [C_LINE_W-1:0] stat_lines_out;

    always #5 clk = ~clk;

    video_decimator #(.C_LANES(C_LANES), .C_PIX_W(C_PIX_W), .C_LINE_W(C_LINE_W)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_hshift(cfg_hshift), .cfg_vshift(cfg_vshift),
        .cfg_hphase(cfg_hphase), .cfg_vphase(cfg_vphase), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep), .m_sof(m_sof), .m_eol(m_eol), .err_sof(err_sof),
        .stat_lines_out(stat_lines_out)
    );

    exp_t          exp_q[$];
    logic [DW-1:0] beats[$];
    bit            eols[$];
    int            checks = 0, errors = 0, err_cnt = 0, pix_ctr = 0;
    int            f_en, f_hs, f_vs, f_hp, f_vp;
    int            lat_mode = 0;
    bit            lat_prev = 0, rnd_ready = 0;

    always @(posedge clk) begin
        #1;
        if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every output transfer pops one expected beat.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got d=%h k=%h sof=%b eol=%b, required no beat", m_data, m_keep, m_sof, m_eol);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.d || m_keep !== e.k || m_sof !== e.s || m_eol !== e.e) begin
                    errors++;
                    $display("FAIL out_beat: got d=%h k=%h sof=%b eol=%b, required d=%h k=%h sof=%b eol=%b",
                             m_data, m_keep, m_sof, m_eol, e.d, e.k, e.s, e.e);
                end
            end
        end
        if (err_sof) err_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic set_frame(input int en, input int hs, input int vs, input int hp, input int vp);
        f_en = en; f_hs = hs; f_vs = vs; f_hp = hp; f_vp = vp;
    endtask

    task automatic apply_cfg();
        cfg_en = 1'(f_en); cfg_hshift = 2'(f_hs); cfg_vshift = 2'(f_vs);
        cfg_hphase = 3'(f_hp); cfg_vphase = 3'(f_vp);
    endtask

    task automatic new_frame();
        beats.delete();
        eols.delete();
        pix_ctr = 0;
    endtask

    task automatic add_line(input int nb, input bit seq);
        logic [DW-1:0] d;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int i = 0; i < C_LANES; i++) begin
                d = d | (DW'(seq ? C_PIX_W'(pix_ctr) : C_PIX_W'($urandom)) << (i*C_PIX_W));
                pix_ctr++;
            end
            beats.push_back(d);
            eols.push_back(b == nb - 1);
        end
    endtask

    // Reference: kept lines contribute every H-th pixel from the phase on; the pixel stream of
    // each kept line is cut into beats of C_LANES, the last beat of the line carrying eol.
    task automatic model_frame(output int kept);
        int H, V, hp, vp, line;
        bit first;
        logic [C_PIX_W-1:0] pix[$];
        logic [DW-1:0] bt;
        exp_t e;
        H = f_en != 0 ? (1 << f_hs) : 1;
        V = f_en != 0 ? (1 << f_vs) : 1;
        hp = f_hp % H;
        vp = f_vp % V;
        line = 0; first = 1; kept = 0;
        for (int b = 0; b < beats.size(); b++) begin
            bt = beats[b];
            if (line % V == vp) begin
                for (int k = 0; k < C_LANES / H; k++)
                    pix.push_back(C_PIX_W'(bt >> ((k*H + hp)*C_PIX_W)));
                if (pix.size() == C_LANES || eols[b]) begin
                    e = '0;
                    foreach (pix[i]) begin
                        e.d = e.d | (DW'(pix[i]) << (i*C_PIX_W));
                        e.k = e.k | (C_LANES'(1) << i);
                    end
                    e.s = first;
                    e.e = eols[b];
                    first = 0;
                    exp_q.push_back(e);
                    pix.delete();
                    if (eols[b]) kept++;
                end
            end
            if (eols[b]) line++;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic sof, input logic eol);
        bit ok;
        ok = 0;
        s_valid = 1; s_data = d; s_sof = sof; s_eol = eol;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (t == 0 && lat_mode > 0) chk("s_ready_free", DW'(s_ready), DW'(1));
            if (t == 0 && lat_mode > 1) chk("latency1", DW'(m_valid), DW'(lat_prev));
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: beat not accepted in 400 cycles, required acceptance");
        end
        lat_prev = 1;
        s_valid = 0; s_sof = 0; s_eol = 0;
    endtask

    task automatic drive_frame(input int gap_max);
        for (int b = 0; b < beats.size(); b++) begin
            if (b == 0) apply_cfg();
            send_beat(beats[b], b == 0, eols[b]);
            if (b == 0) begin
                cfg_en = 1'($urandom); cfg_hshift = 2'($urandom); cfg_vshift = 2'($urandom);
                cfg_hphase = 3'($urandom); cfg_vphase = 3'($urandom);
            end
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
        end
    endtask

    task automatic run_frame(input string nm, input int gap_max);
        int kept;
        model_frame(kept);
        drive_frame(gap_max);
        drain();
        @(negedge clk);
        chk({nm, "_stat_lines"}, DW'(stat_lines_out), DW'(kept));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int kept, err_base;
        s_valid = 0; s_data = '0; s_sof = 0; s_eol = 0; m_ready = 0;
        set_frame(0, 0, 0, 0, 0);
        apply_cfg();
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1; s_sof = 1; s_eol = 1; m_ready = 1;
        @(negedge clk);
        chk("rst_s_ready", DW'(s_ready), '0);
        chk("rst_m_valid", DW'(m_valid), '0);
        chk("rst_m_sof", DW'(m_sof), '0);
        chk("rst_m_eol", DW'(m_eol), '0);
        chk("rst_err_sof", DW'(err_sof), '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_m_keep", DW'(m_keep), '0);
        chk("rst_stat", DW'(stat_lines_out), '0);
        @(posedge clk);
        #1;
        s_valid = 0; s_sof = 0; s_eol = 0; rst = 0;

        // Bypass ignores shift/phase settings; one beat per clock with latency 1.
        set_frame(0, 3, 2, 5, 3);
        new_frame(); add_line(2, 1); add_line(2, 1);
        lat_mode = 2; lat_prev = 0;
        run_frame("bypass", 0);
        lat_mode = 0;

        set_frame(1, 1, 0, 1, 0);
        new_frame(); add_line(2, 1);
        run_frame("h2", 0);

        set_frame(1, 2, 0, 2, 0);
        new_frame(); add_line(6, 1);
        run_frame("h4_partial", 0);

        set_frame(1, 0, 1, 0, 1);
        new_frame(); repeat (4) add_line(1, 1);
        lat_mode = 1;
        run_frame("v2", 0);
        lat_mode = 0;

        // Backpressure: second beat must stall while the first is held.
        m_ready = 0;
        set_frame(1, 0, 0, 0, 0);
        new_frame(); add_line(2, 0);
        model_frame(kept);
        apply_cfg();
        send_beat(beats[0], 1, 0);
        s_valid = 1; s_data = beats[1]; s_sof = 0; s_eol = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_s_ready", DW'(s_ready), '0);
            chk("bp_m_valid", DW'(m_valid), DW'(1));
            chk("bp_m_data", m_data, beats[0]);
            @(posedge clk);
            #1;
        end
        m_ready = 1;
        send_beat(beats[1], 0, 1);
        drain();
        @(negedge clk);
        chk("bp_stat_lines", DW'(stat_lines_out), DW'(kept));
        @(posedge clk);
        #1;

        // sof after half a group: partial discarded, err_sof pulses once.
        err_base = err_cnt;
        set_frame(1, 1, 0, 0, 0);
        apply_cfg();
        new_frame(); add_line(1, 0);
        send_beat(beats[0], 1, 0);
        new_frame(); add_line(2, 0);
        run_frame("after_abort", 0);
        chk("err_sof_pulse", DW'(err_cnt - err_base), DW'(1));

        // Reset mid-frame with an output held, then stray beats before any sof.
        m_ready = 0;
        set_frame(1, 0, 0, 0, 0);
        apply_cfg();
        new_frame(); add_line(2, 0);
        send_beat(beats[0], 1, 0);
        @(negedge clk);
        chk("pre_rst_m_valid", DW'(m_valid), DW'(1));
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_m_valid", DW'(m_valid), '0);
        chk("mid_rst_m_data", m_data, '0);
        chk("mid_rst_m_keep", DW'(m_keep), '0);
        chk("mid_rst_m_sof", DW'(m_sof), '0);
        chk("mid_rst_stat", DW'(stat_lines_out), '0);
        chk("mid_rst_s_ready", DW'(s_ready), '0);
        @(posedge clk);
        #1;
        rst = 0; m_ready = 1;
        exp_q.delete();
        new_frame(); add_line(3, 0);
        for (int b = 0; b < 3; b++) send_beat(beats[b], 0, b == 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("no_sof_m_valid", DW'(m_valid), '0);
        @(posedge clk);
        #1;

        rnd_ready = 1;
        for (int f = 0; f < 40; f++) begin
            set_frame($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 7), $urandom_range(0, 7));
            new_frame();
            repeat ($urandom_range(1, 6)) add_line($urandom_range(1, 9), 0);
            run_frame("rand", 2);
        end
        rnd_ready = 0;
        chk("err_sof_total", DW'(err_cnt), DW'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
